stream_mux_nto1: RTL and testbench

//   Parametrised N-to-1 multiplexer for W-bit valid/ready streams.

---
 rtl/stream_mux_nto1_if.sv | 28 ++
 rtl/stream_mux_nto1.sv | 113 +++++++++++
 tb/tb_stream_mux_nto1.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_nto1_if.sv
// Valid/ready bundle for the N-to-1 stream multiplexer: N input channels plus one output stream.
interface stream_mux_nto1_if #(
  parameter int N = 8,
  parameter int W = 8
) ();
  localparam int SELW = $clog2(N);

  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_last;
  logic [SELW-1:0] out_ch;
  logic            out_ready;

  modport slave (
    input  in_data, in_valid, in_last, sel, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ch
  );

  modport master (
    output in_data, in_valid, in_last, sel, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream mux with a registered output beat.
// Arbitration is either fixed select or round-robin, and a grant stays locked until in_last.
//   state  | meaning
//   IDLE   | no packet in flight; grant chosen by sel (MODE=0) or round-robin (MODE=1)
//   LOCKED | mid-packet; only lock_ch may transfer until its in_last beat is accepted
module stream_mux_nto1 #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int MODE = 0,
  parameter int SELW = $clog2(N)
) (
  input logic              clk,
  input logic              rst,
  stream_mux_nto1_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [SELW-1:0] lock_ch;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] g;
  logic            grant_vld;
  logic            can_load;
  logic            accept;
  logic            last_g;

  assign can_load = !bus.out_valid || bus.out_ready;
  assign accept   = grant_vld && can_load;
  assign last_g   = bus.in_last[g];

  // Grant selection. In round-robin, the loop runs from the farthest candidate
  // down to the nearest, so the nearest valid channel after rr_ptr wins.
  always_comb begin
    logic [SELW-1:0] idx;
    g         = '0;
    grant_vld = 1'b0;
    idx       = '0;
    if (state == LOCKED) begin
      g         = lock_ch;
      grant_vld = bus.in_valid[lock_ch];
    end else if (MODE == 0) begin
      g = bus.sel;
      if (int'(bus.sel) < N) begin
        grant_vld = bus.in_valid[bus.sel];
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        idx = SELW'((int'(rr_ptr) + k) % N);
        if (bus.in_valid[idx]) begin
          g         = idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !last_g) state_nxt = LOCKED;
      LOCKED:  if (accept && last_g)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = '0;
    if (accept) begin
      bus.in_ready[g] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_ch <= '0;
      rr_ptr  <= SELW'(N - 1);
    end else if (accept) begin
      if (state == IDLE && !last_g) begin
        lock_ch <= g;
      end
      if (last_g) begin
        rr_ptr <= g;
      end
    end
  end

  // A drain and a load on the same edge simply overwrite the old beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_ch    <= '0;
    end else if (can_load) begin
      bus.out_valid <= accept;
      if (accept) begin
        bus.out_data <= bus.in_data[int'(g)*W +: W];
        bus.out_last <= last_g;
        bus.out_ch   <= g;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench for stream_mux_nto1: fixed select and round-robin with N=8, plus fixed select with N=6.
module tb_stream_mux_nto1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchecks = 0;
  int   nerrors = 0;

  always #5 clk = ~clk;

  stream_mux_nto1_if #(.N(8), .W(8)) b0 ();
  stream_mux_nto1_if #(.N(8), .W(8)) b1 ();
  stream_mux_nto1_if #(.N(6), .W(8)) b2 ();

  stream_mux_nto1 #(.N(8), .W(8), .MODE(0)) u_fix  (.clk(clk), .rst(rst), .bus(b0));
  stream_mux_nto1 #(.N(8), .W(8), .MODE(1)) u_rr   (.clk(clk), .rst(rst), .bus(b1));
  stream_mux_nto1 #(.N(6), .W(8), .MODE(0)) u_fix6 (.clk(clk), .rst(rst), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      b0.in_data[i*8 +: 8] = 8'(8'hA0 + i);
      b1.in_data[i*8 +: 8] = 8'(8'hA0 + i);
    end
    for (int i = 0; i < 6; i++) begin
      b2.in_data[i*8 +: 8] = 8'(8'hA0 + i);
    end
    b0.in_valid = '0; b0.in_last = '1; b0.sel = '0; b0.out_ready = 1'b1;
    b1.in_valid = '0; b1.in_last = '1; b1.sel = '0; b1.out_ready = 1'b1;
    b2.in_valid = '0; b2.in_last = '1; b2.sel = '0; b2.out_ready = 1'b1;

    // reset values
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", b1.out_valid, 0);
    chk("rst_data",  b1.out_data, 8'h00);
    chk("rst_last",  b1.out_last, 0);
    chk("rst_ch",    b1.out_ch, 0);
    chk("rst_valid_fix", b0.out_valid, 0);
    rst = 1'b0;

    // 1: fixed select sweeps sel 0..7
    b0.in_valid = 8'hFF;
    for (int s = 0; s < 8; s++) begin
      b0.sel = 3'(s);
      #1;
      chk("t1_ready", b0.in_ready, 32'(1) << s);
      tick();
      chk("t1_data",  b0.out_data, 8'hA0 + s);
      chk("t1_ch",    b0.out_ch, s);
      chk("t1_valid", b0.out_valid, 1);
    end
    chk("t1_data7", b0.out_data, 8'hA7);
    b0.in_valid = 8'h00;
    tick();
    chk("t1_drain", b0.out_valid, 0);

    // 2: round-robin, all channels valid
    b1.in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("t2_ch",    b1.out_ch, k % 8);
      chk("t2_valid", b1.out_valid, 1);
    end

    // 3: backpressure holds the ch0 beat
    b1.out_ready = 1'b0;
    #1;
    chk("t3_ready0", b1.in_ready, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_ch",   b1.out_ch, 0);
      chk("t3_hold_data", b1.out_data, 8'hA0);
      chk("t3_hold_vld",  b1.out_valid, 1);
      chk("t3_ready",     b1.in_ready, 8'h00);
    end
    b1.out_ready = 1'b1;
    tick();
    chk("t3_resume1", b1.out_ch, 1);
    tick();
    chk("t3_resume2", b1.out_ch, 2);
    b1.in_valid = 8'h00;
    tick();
    chk("t3_drain", b1.out_valid, 0);

    // 4: ch2 3-beat packet locks out ch5 (first park rr_ptr on ch1)
    b1.in_valid = 8'h02;
    tick();
    chk("t4_pre_ch", b1.out_ch, 1);
    b1.in_valid = 8'h24;
    b1.in_last  = 8'hFB;
    #1;
    chk("t4_ready_a", b1.in_ready, 8'h04);
    tick();
    chk("t4_b1_ch",   b1.out_ch, 2);
    chk("t4_b1_last", b1.out_last, 0);
    chk("t4_ready_b", b1.in_ready, 8'h04);
    tick();
    chk("t4_b2_ch",   b1.out_ch, 2);
    chk("t4_b2_last", b1.out_last, 0);
    b1.in_last = 8'hFF;
    #1;
    chk("t4_ready_c", b1.in_ready, 8'h04);
    tick();
    chk("t4_b3_ch",   b1.out_ch, 2);
    chk("t4_b3_last", b1.out_last, 1);
    chk("t4_ready_d", b1.in_ready, 8'h20);
    tick();
    chk("t4_ch5",      b1.out_ch, 5);
    chk("t4_ch5_data", b1.out_data, 8'hA5);
    b1.in_valid = 8'h00;
    tick();
    chk("t4_drain", b1.out_valid, 0);

    // 5: fixed select lock survives a sel change mid-packet
    b0.in_valid = 8'hFF;
    b0.in_last  = 8'hFD;
    b0.sel      = 3'd1;
    tick();
    chk("t5_b1_ch",   b0.out_ch, 1);
    chk("t5_b1_last", b0.out_last, 0);
    b0.sel     = 3'd6;
    b0.in_last = 8'hFF;
    #1;
    chk("t5_ready_lock", b0.in_ready, 8'h02);
    tick();
    chk("t5_b2_ch",   b0.out_ch, 1);
    chk("t5_b2_data", b0.out_data, 8'hA1);
    chk("t5_b2_last", b0.out_last, 1);
    tick();
    chk("t5_ch6",      b0.out_ch, 6);
    chk("t5_ch6_data", b0.out_data, 8'hA6);

    // 5b: N=6, sel out of range grants nothing; sel=5 is the top channel
    b2.in_valid = 6'h3F;
    b2.sel      = 3'd7;
    #1;
    chk("t5_n6_ready", b2.in_ready, 6'h00);
    tick();
    chk("t5_n6_novld", b2.out_valid, 0);
    b2.sel = 3'd5;
    #1;
    chk("t5_n6_ready5", b2.in_ready, 6'h20);
    tick();
    chk("t5_n6_ch5",   b2.out_ch, 5);
    chk("t5_n6_data5", b2.out_data, 8'hA5);

    // 6: reset mid-packet on ch4
    b1.in_valid = 8'h10;
    b1.in_last  = 8'hEF;
    tick();
    chk("t6_ch4",      b1.out_ch, 4);
    chk("t6_ch4_last", b1.out_last, 0);
    b1.in_valid = 8'hFF;
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", b1.out_valid, 0);
    chk("t6_rst_ch",    b1.out_ch, 0);
    rst = 1'b0;
    b1.in_last = 8'hFF;
    #1;
    chk("t6_ready", b1.in_ready, 8'h01);
    tick();
    chk("t6_first_ch",   b1.out_ch, 0);
    chk("t6_first_vld",  b1.out_valid, 1);
    chk("t6_first_data", b1.out_data, 8'hA0);
    tick();
    chk("t6_second_ch", b1.out_ch, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
